// File: rtl/fft_ucode_seq.sv
// Microcoded FFT control sequencer with a run-time loadable microcode RAM.
// Issues mem[0..la] once per frame, back-to-back over the frame count.
module fft_ucode_seq #(
   parameter int CW    = 15,
   parameter int AW    = 8,
   parameter int DEPTH = 203,
   parameter int NFW   = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [NFW-1:0] nframes,
   input  logic [AW-1:0]  last_addr,
   input  logic           stall,
   input  logic           abort,
   input  logic           prog_we,
   input  logic [AW-1:0]  prog_addr,
   input  logic [CW-1:0]  prog_data,
   output logic [CW-1:0]  ctrl,
   output logic           ctrl_valid,
   output logic           frame_done,
   output logic           busy,
   output logic           done
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

   state_t         state, state_n;
   logic [AW-1:0]  pc, pc_n, la, la_n;
   logic [NFW-1:0] frem, frem_n;
   logic           valid_n, fd_n, busy_n, done_n;
   logic           accept, adv, at_last, more, wr_ok;
   logic [CW-1:0]  mem [DEPTH];

   // busy stays high through the final-word cycle, which already sits in IDLE
   assign accept  = (state == IDLE) && start && !busy;
   assign adv     = (state == RUN) && !abort && !stall;
   assign at_last = (pc == la);
   assign more    = (frem > NFW'(1));
   assign wr_ok   = prog_we && !busy && !rst && (32'(prog_addr) < DEPTH);

   always_ff @(posedge clk) begin
      if (wr_ok) mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (rst)
         ctrl <= '0;
      else if (adv)
         ctrl <= mem[pc];
      else if (state == IDLE || abort)
         ctrl <= '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= '0;
         frem       <= '0;
         la         <= '0;
         ctrl_valid <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         frem       <= frem_n;
         la         <= la_n;
         ctrl_valid <= valid_n;
         frame_done <= fd_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (accept) state_n = RUN;
         RUN:  if (abort || (adv && at_last && !more)) state_n = IDLE;
      endcase
   end

   always_comb begin
      pc_n    = pc;
      frem_n  = frem;
      la_n    = la;
      valid_n = 1'b0;
      fd_n    = 1'b0;
      busy_n  = busy;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            busy_n = accept;
            // a frame_done seen in IDLE marks the final word of a clean run
            done_n = frame_done;
            if (accept) begin
               pc_n   = '0;
               la_n   = (last_addr > LAST_MAX) ? LAST_MAX : last_addr;
               frem_n = (nframes == '0) ? NFW'(1) : nframes;
            end
         end
         RUN: begin
            if (abort) begin
               busy_n = 1'b0;
            end else if (!stall) begin
               valid_n = 1'b1;
               if (!at_last) begin
                  pc_n = pc + 1'b1;
               end else begin
                  fd_n = 1'b1;
                  if (more) begin
                     frem_n = frem - 1'b1;
                     pc_n   = '0;
                  end
               end
            end
         end
      endcase
   end
endmodule

// File: tb/tb_fft_ucode_seq.sv
// Self-checking bench for fft_ucode_seq against a word-stream model.
// Expected ctrl stream is built from a shadow copy of the microcode RAM.
module tb_fft_ucode_seq;
   localparam int CW = 15, AW = 8, DEPTH = 203, NFW = 4;

   logic           clk = 1'b0;
   logic           rst, start, stall, abort, prog_we;
   logic [NFW-1:0] nframes;
   logic [AW-1:0]  last_addr, prog_addr;
   logic [CW-1:0]  prog_data;
   logic [CW-1:0]  ctrl;
   logic           ctrl_valid, frame_done, busy, done;

   int total = 0;
   int bad = 0;
   int mem_m [DEPTH];

   always #5 clk = ~clk;

   fft_ucode_seq #(.CW(CW), .AW(AW), .DEPTH(DEPTH), .NFW(NFW)) dut (
      .clk(clk), .rst(rst), .start(start), .nframes(nframes),
      .last_addr(last_addr), .stall(stall), .abort(abort),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .ctrl(ctrl), .ctrl_valid(ctrl_valid), .frame_done(frame_done),
      .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctrl"}, ctrl, 0);
      chk({tag, "_valid"}, ctrl_valid, 0);
      chk({tag, "_fd"}, frame_done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic prog(input int a, input int d);
      prog_we = 1'b1;
      prog_addr = AW'(a);
      prog_data = CW'(d);
      @(negedge clk);
      prog_we = 1'b0;
      if (a < DEPTH) mem_m[a] = d;
   endtask

   // Returns at the negedge of the done cycle (or a few cycles after an abort).
   task automatic run(input int nf, input int lad, input int stall_w,
                      input int nstall, input int abort_w,
                      input bit wr_busy, input bit wr_start);
      int L, F, tot, w, nst, bcnt;
      bit stl_prev, ab_prev, fin;
      L = (lad > DEPTH - 1) ? DEPTH - 1 : lad;
      F = (nf == 0) ? 1 : nf;
      tot = (L + 1) * F;
      nframes = NFW'(nf);
      last_addr = AW'(lad);
      start = 1'b1;
      if (wr_start) begin
         prog_we = 1'b1;
         prog_addr = '0;
         prog_data = 15'h7fff;
         mem_m[0] = 32'h7fff;
      end
      @(negedge clk);
      start = 1'b0;
      prog_we = 1'b0;
      chk("run_busy", busy, 1);
      chk("run_first_valid", ctrl_valid, 0);
      if (wr_busy) begin
         prog_we = 1'b1;
         prog_addr = '0;
         prog_data = 15'h7fff;
      end
      w = 0; nst = 0; bcnt = int'(busy);
      stl_prev = 0; ab_prev = 0; fin = 0;
      for (int c = 1; c <= tot + nstall + 4 && !fin; c++) begin
         @(negedge clk);
         prog_we = 1'b0;
         stall = 1'b0;
         abort = 1'b0;
         bcnt += int'(busy);
         if (ab_prev) begin
            chk("abort_busy", busy, 0);
            chk("abort_ctrl", ctrl, 0);
            chk("abort_valid", ctrl_valid, 0);
            chk("abort_fd", frame_done, 0);
            repeat (3) begin
               @(negedge clk);
               chk("abort_nodone", done, 0);
            end
            fin = 1;
         end else if (stl_prev) begin
            chk("stall_valid", ctrl_valid, 0);
            chk("stall_hold", ctrl, mem_m[(w - 1) % (L + 1)]);
            chk("stall_fd", frame_done, 0);
         end else if (w < tot) begin
            chk("word", ctrl, mem_m[w % (L + 1)]);
            chk("word_valid", ctrl_valid, 1);
            chk("word_fd", frame_done, (w % (L + 1)) == L);
            chk("word_nodone", done, 0);
            w++;
         end else begin
            chk("done", done, 1);
            chk("done_busy", busy, 0);
            chk("done_ctrl", ctrl, 0);
            chk("done_valid", ctrl_valid, 0);
            chk("done_cycle", c, tot + nst + 1);
            chk("busy_cycles", bcnt, tot + nst + 1);
            fin = 1;
         end
         if (!fin) begin
            ab_prev = (abort_w >= 0) && (w == abort_w + 1) && (w < tot);
            stl_prev = !ab_prev && (stall_w >= 0) && (w == stall_w + 1)
                       && (nst < nstall) && (w < tot);
            if (stl_prev) nst++;
            abort = ab_prev;
            stall = stl_prev;
         end
      end
      if (!fin) chk("timeout", 0, 1);
      stall = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      int nf, lad, sw, ns, aw, L, tot;
      rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
      prog_we = 1'b0; nframes = '0; last_addr = '0;
      prog_addr = '0; prog_data = '0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      for (int a = 0; a < DEPTH; a++) prog(a, a + 'h100);

      run(1, 'hCA, -1, 0, -1, 0, 0);
      run(3, 3, -1, 0, -1, 0, 0);
      run(1, 5, 2, 2, -1, 0, 0);
      run(3, 3, -1, 0, 4, 0, 0);
      run(1, 3, -1, 0, -1, 0, 0);
      run(1, 3, -1, 0, -1, 1, 0);
      run(1, 3, -1, 0, -1, 0, 0);
      run(1, 3, -1, 0, -1, 0, 1);
      prog(0, 'h100);

      run(2, 2, -1, 0, -1, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("rst_done");
      rst = 1'b0;

      nframes = 2; last_addr = 10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("rst_mid");
      rst = 1'b0;
      @(negedge clk);
      chk_zero("rst_mid_after");

      run(0, 'hFF, -1, 0, -1, 0, 0);

      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 3))
            prog($urandom_range(0, 255), $urandom_range(0, 32767));
         nf = $urandom_range(0, 4);
         lad = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255)
                                           : $urandom_range(0, 12);
         L = (lad > DEPTH - 1) ? DEPTH - 1 : lad;
         tot = (L + 1) * ((nf == 0) ? 1 : nf);
         sw = -1; ns = 0; aw = -1;
         if (tot >= 2 && $urandom_range(0, 1) == 1) begin
            sw = $urandom_range(0, tot - 2);
            ns = $urandom_range(1, 3);
         end else if (tot >= 2 && $urandom_range(0, 3) == 0) begin
            aw = $urandom_range(0, tot - 2);
         end
         run(nf, lad, sw, ns, aw, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
